// File: rtl/vec_store_unit.sv
// Vector strided store unit: walks the elements of one captured vector register
// and issues one memory write request per element, with a configurable byte stride.
module vec_store_unit #(
    parameter int XLEN  = 32,
    parameter int VLEN  = 512,
    parameter int VLMAX = 16,
    parameter int SEW   = 32,
    parameter int LMUL  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [XLEN-1:0]      rs1_data,
    input  logic [XLEN-1:0]      rs2_data,
    input  logic                 stride_sel,
    input  logic                 st_inst,
    input  logic                 mew,
    input  logic [2:0]           width,
    input  logic [4:0]           vl,
    input  logic [VLEN*LMUL-1:0] vs3_data,
    output logic [XLEN-1:0]      lsu2mem_addr,
    output logic [SEW-1:0]       lsu2mem_data,
    output logic                 lsu2mem_wen,
    output logic [3:0]           lsu2mem_wmask,
    input  logic                 mem2lsu_ready,
    output logic                 busy,
    output logic                 is_stored,
    output logic                 store_err
);

    localparam int NELEM = (VLEN * LMUL) / SEW;
    localparam int IDX_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STORE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        addr_q, addr_d;
    logic [SEW-1:0]         data_q, data_d;
    logic [3:0]             wmask_q, wmask_d;
    logic                   wen_q, wen_d;
    logic                   busy_q, busy_d;
    logic                   stored_q, stored_d;
    logic                   err_out_q, err_out_d;
    logic                   err_pend_q, err_pend_d;
    logic [XLEN-1:0]        stride_q, stride_d;
    logic [1:0]             esz_q, esz_d;
    logic [IDX_W-1:0]       vl_q, vl_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VLEN*LMUL-1:0]   vs3_q, vs3_d;

    logic                   width_ok;
    logic [1:0]             esz_in;
    logic                   bad_in;
    logic [VLEN*LMUL-1:0]   sel_vec;
    logic [IDX_W-1:0]       sel_idx;
    logic [1:0]             sel_esz;
    logic [SEW-1:0]         sel_elem;
    logic [SEW-1:0]         elem_keep;

    // Element size code: 0 = byte, 1 = halfword, 2 = word.
    function automatic logic [SEW-1:0] keep_mask(input logic [1:0] esz);
        case (esz)
            2'd0:    keep_mask = SEW'(8'hFF);
            2'd1:    keep_mask = SEW'(16'hFFFF);
            default: keep_mask = '1;
        endcase
    endfunction

    function automatic logic [3:0] wmask_of(input logic [1:0] esz);
        case (esz)
            2'd0:    wmask_of = 4'b0001;
            2'd1:    wmask_of = 4'b0011;
            default: wmask_of = 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] unit_stride(input logic [1:0] esz);
        case (esz)
            2'd0:    unit_stride = XLEN'(1);
            2'd1:    unit_stride = XLEN'(2);
            default: unit_stride = XLEN'(4);
        endcase
    endfunction

    // Decode the requested element width and flag reserved encodings.
    always_comb begin
        width_ok = 1'b1;
        esz_in   = 2'd2;
        case (width)
            3'b000:  esz_in = 2'd0;
            3'b101:  esz_in = 2'd1;
            3'b110:  esz_in = 2'd2;
            default: width_ok = 1'b0;
        endcase
        bad_in = mew | ~width_ok | (vl > IDX_W'(VLMAX));
    end

    // Pick the element to present next: element 0 of the live input on capture,
    // otherwise the element after the current one from the captured copy.
    always_comb begin
        sel_vec = vs3_q;
        sel_idx = idx_q + IDX_W'(1);
        sel_esz = esz_q;
        if (state_q == S_IDLE) begin
            sel_vec = vs3_data;
            sel_idx = '0;
            sel_esz = esz_in;
        end
        sel_elem = '0;
        for (int i = 0; i < NELEM; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_elem = sel_vec[i*SEW +: SEW];
            end
        end
        elem_keep = sel_elem & keep_mask(sel_esz);
    end

    // Next-state and registered-output logic for the IDLE/STORE/DONE sequence.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wmask_d    = wmask_q;
        wen_d      = wen_q;
        busy_d     = busy_q;
        stored_d   = 1'b0;
        err_out_d  = 1'b0;
        err_pend_d = err_pend_q;
        stride_d   = stride_q;
        esz_d      = esz_q;
        vl_d       = vl_q;
        idx_d      = idx_q;
        vs3_d      = vs3_q;
        case (state_q)
            S_IDLE: begin
                if (st_inst) begin
                    vs3_d    = vs3_data;
                    vl_d     = vl;
                    esz_d    = esz_in;
                    idx_d    = '0;
                    stride_d = stride_sel ? unit_stride(esz_in) : rs2_data;
                    if (bad_in || (vl == '0)) begin
                        state_d    = S_DONE;
                        err_pend_d = bad_in;
                    end else begin
                        state_d = S_STORE;
                        wen_d   = 1'b1;
                        busy_d  = 1'b1;
                        addr_d  = rs1_data;
                        data_d  = elem_keep;
                        wmask_d = wmask_of(esz_in);
                    end
                end
            end
            S_STORE: begin
                if (mem2lsu_ready) begin
                    if (idx_q == (vl_q - IDX_W'(1))) begin
                        state_d = S_DONE;
                        wen_d   = 1'b0;
                        busy_d  = 1'b0;
                        addr_d  = '0;
                        data_d  = '0;
                        wmask_d = '0;
                    end else begin
                        idx_d  = idx_q + IDX_W'(1);
                        addr_d = addr_q + stride_q;
                        data_d = elem_keep;
                    end
                end
            end
            S_DONE: begin
                stored_d   = 1'b1;
                err_out_d  = err_pend_q;
                err_pend_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset aborts any store in flight and clears every output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wmask_q    <= '0;
            wen_q      <= 1'b0;
            busy_q     <= 1'b0;
            stored_q   <= 1'b0;
            err_out_q  <= 1'b0;
            err_pend_q <= 1'b0;
            stride_q   <= '0;
            esz_q      <= '0;
            vl_q       <= '0;
            idx_q      <= '0;
            vs3_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wmask_q    <= wmask_d;
            wen_q      <= wen_d;
            busy_q     <= busy_d;
            stored_q   <= stored_d;
            err_out_q  <= err_out_d;
            err_pend_q <= err_pend_d;
            stride_q   <= stride_d;
            esz_q      <= esz_d;
            vl_q       <= vl_d;
            idx_q      <= idx_d;
            vs3_q      <= vs3_d;
        end
    end

    assign lsu2mem_addr  = addr_q;
    assign lsu2mem_data  = data_q;
    assign lsu2mem_wmask = wmask_q;
    assign lsu2mem_wen   = wen_q;
    assign busy          = busy_q;
    assign is_stored     = stored_q;
    assign store_err     = err_out_q;

endmodule
